// File: rtl/lif_pkg.sv
// Shared constants and FSM state encoding for the time-multiplexed LIF neuron scheduler.
package lif_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_UPDATE = 3'd2,
    ST_WRITE  = 3'd3
  } lif_state_e;

  localparam int          LIF_WIDTH  = 8;
  localparam logic [7:0]  LIF_THRESH = 8'd20;
  localparam logic [7:0]  LIF_ADD_W  = 8'd20;
  localparam logic [7:0]  LIF_LEAK   = 8'd1;
  localparam logic [7:0]  LIF_VRESET = 8'd0;

endpackage

// File: rtl/lif_tdm_scheduler_if.sv
// Control/event bus of the LIF scheduler: the master drives enable and input events,
// the slave (scheduler) returns spikes and its debug view.
interface lif_tdm_scheduler_if #(
  parameter int N_NEURONS = 4
) ();
  localparam int IDX_W = $clog2(N_NEURONS);

  logic                 enable;
  logic [N_NEURONS-1:0] signal_in;
  logic [N_NEURONS-1:0] spike_out;
  logic [IDX_W-1:0]     cur_idx;
  logic [2:0]           state_dbg;

  modport master (output enable, signal_in, input spike_out, cur_idx, state_dbg);
  modport slave  (input enable, signal_in, output spike_out, cur_idx, state_dbg);
endinterface

// File: rtl/lif_potential_rf.sv
// Membrane potential storage: one combinational read port, one synchronous write port,
// synchronous clear while rst_n is low (clear wins over a concurrent write).
module lif_potential_rf #(
  parameter int N_NEURONS = 4,
  parameter int WIDTH     = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [$clog2(N_NEURONS)-1:0] raddr_i,
  output logic [WIDTH-1:0]             rdata_o,
  input  logic                         we_i,
  input  logic [$clog2(N_NEURONS)-1:0] waddr_i,
  input  logic [WIDTH-1:0]             wdata_i
);
  logic [N_NEURONS-1:0][WIDTH-1:0] mem_q;

  assign rdata_o = mem_q[raddr_i];

  // potential array: clear on reset, else single write port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end
endmodule

// File: rtl/lif_tdm_scheduler.sv
// Time-multiplexed leaky integrate-and-fire scheduler: one datapath services each neuron
// in turn (LOAD/UPDATE/WRITE). Optional refractory counters under macro LIF_REFRACTORY_EN.
module lif_tdm_scheduler
  import lif_pkg::*;
#(
  parameter int               N_NEURONS = 4,
  parameter int               WIDTH     = LIF_WIDTH,
  parameter logic [WIDTH-1:0] THRESH    = LIF_THRESH,
  parameter logic [WIDTH-1:0] ADD_W     = LIF_ADD_W,
  parameter logic [WIDTH-1:0] LEAK      = LIF_LEAK,
  parameter logic [WIDTH-1:0] VRESET    = LIF_VRESET,
  parameter int               REFRACT   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  lif_tdm_scheduler_if.slave  bus
);
  localparam int               IDX_W    = $clog2(N_NEURONS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_NEURONS - 1);

  lif_state_e           state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [N_NEURONS-1:0] pend_q, pend_d;
  logic [N_NEURONS-1:0] spike_q, spike_d;
  logic [WIDTH-1:0]     v_q, v_d, v_upd, rdata, wdata;
  logic                 evt_q, evt_d, we;

  function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[WIDTH] ? {WIDTH{1'b1}} : s[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] floor_sub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return (a < b) ? {WIDTH{1'b0}} : (a - b);
  endfunction

`ifdef LIF_REFRACTORY_EN
  localparam int RW = (REFRACT < 1) ? 1 : $clog2(REFRACT + 1);
  logic [N_NEURONS-1:0][RW-1:0] ref_q, ref_d;
  logic                         refr_q, refr_d;
  assign v_upd = refr_q ? VRESET : (evt_q ? sat_add(v_q, ADD_W) : floor_sub(v_q, LEAK));
`else
  assign v_upd = evt_q ? sat_add(v_q, ADD_W) : floor_sub(v_q, LEAK);
`endif

  lif_potential_rf #(.N_NEURONS(N_NEURONS), .WIDTH(WIDTH)) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .raddr_i (idx_q),
    .rdata_o (rdata),
    .we_i    (we),
    .waddr_i (idx_q),
    .wdata_i (wdata)
  );

  // slot sequencing, event bookkeeping and write-back selection
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pend_d  = pend_q | bus.signal_in;
    spike_d = {N_NEURONS{1'b0}};
    v_d     = v_q;
    evt_d   = evt_q;
    we      = 1'b0;
    wdata   = v_q;
`ifdef LIF_REFRACTORY_EN
    ref_d   = ref_q;
    refr_d  = refr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        state_d = bus.enable ? ST_LOAD : ST_IDLE;
      end
      ST_LOAD: begin
        v_d     = rdata;
        state_d = ST_UPDATE;
`ifdef LIF_REFRACTORY_EN
        refr_d         = (ref_q[idx_q] != {RW{1'b0}});
        evt_d          = pend_q[idx_q] & ~refr_d;
        pend_d[idx_q]  = bus.signal_in[idx_q] & ~refr_d;
`else
        // an event arriving in the consuming cycle survives for the next service
        evt_d          = pend_q[idx_q];
        pend_d[idx_q]  = bus.signal_in[idx_q];
`endif
      end
      ST_UPDATE: begin
        v_d            = v_upd;
        spike_d[idx_q] = (v_upd >= THRESH);
        state_d        = ST_WRITE;
      end
      ST_WRITE: begin
        we    = 1'b1;
        wdata = spike_q[idx_q] ? VRESET : v_q;
`ifdef LIF_REFRACTORY_EN
        if (spike_q[idx_q]) begin
          ref_d[idx_q] = RW'(REFRACT);
        end else if (ref_q[idx_q] != {RW{1'b0}}) begin
          ref_d[idx_q] = ref_q[idx_q] - RW'(1);
        end else begin
          ref_d[idx_q] = ref_q[idx_q];
        end
`endif
        // disabling parks on the neuron just written; resuming services it again
        if (bus.enable) begin
          idx_d   = (idx_q == IDX_LAST) ? {IDX_W{1'b0}} : (idx_q + IDX_W'(1));
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
      idx_q   <= {IDX_W{1'b0}};
      pend_q  <= {N_NEURONS{1'b0}};
      spike_q <= {N_NEURONS{1'b0}};
      v_q     <= {WIDTH{1'b0}};
      evt_q   <= 1'b0;
`ifdef LIF_REFRACTORY_EN
      ref_q   <= '0;
      refr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      spike_q <= spike_d;
      v_q     <= v_d;
      evt_q   <= evt_d;
`ifdef LIF_REFRACTORY_EN
      ref_q   <= ref_d;
      refr_q  <= refr_d;
`endif
    end
  end

  assign bus.spike_out = spike_q;
  assign bus.cur_idx   = idx_q;
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_lif_tdm_scheduler.sv
// Self-checking bench: two scheduler instances (ADD_W=8 and ADD_W=200/THRESH=255) against a
// cycle model whose predictions go through a scoreboard queue, plus directed scenario checks.
module tb_lif_tdm_scheduler;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic [3:0] sig_a = 4'b0;
  logic [3:0] sig_b = 4'b0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  lif_tdm_scheduler_if #(.N_NEURONS(4)) if_a ();
  lif_tdm_scheduler_if #(.N_NEURONS(4)) if_b ();
  assign if_a.enable = en;
  assign if_b.enable = en;
  assign if_a.signal_in = sig_a;
  assign if_b.signal_in = sig_b;

  lif_tdm_scheduler #(.N_NEURONS(4), .ADD_W(8'd8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a));
  lif_tdm_scheduler #(.N_NEURONS(4), .ADD_W(8'd200), .THRESH(8'd255)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b));

  typedef struct packed {
    logic [2:0]      st;
    logic [1:0]      idx;
    logic [3:0]      pend;
    logic [3:0][7:0] pot;
    logic [7:0]      v;
    logic            evt;
    logic [3:0]      spike;
  } mdl_t;

  typedef struct packed {
    logic [3:0] spike;
    logic [1:0] idx;
    logic [2:0] st;
  } obs_t;

  mdl_t ma, mb;
  obs_t qa[$];
  obs_t qb[$];

  function automatic mdl_t step(mdl_t m, logic rn, logic e, logic [3:0] s, int addw, int thr);
    mdl_t n;
    int   nv;
    n = m;
    n.spike = 4'b0;
    if (!rn) begin
      n = '0;
      n.st = 3'd1;
      return n;
    end
    n.pend = m.pend | s;
    case (m.st)
      3'd0: n.st = e ? 3'd1 : 3'd0;
      3'd1: begin
        n.v = m.pot[m.idx];
        n.evt = m.pend[m.idx];
        n.pend[m.idx] = s[m.idx];
        n.st = 3'd2;
      end
      3'd2: begin
        nv = m.evt ? (int'(m.v) + addw) : (int'(m.v) - 1);
        if (nv > 255) nv = 255;
        if (nv < 0) nv = 0;
        n.v = 8'(nv);
        n.spike[m.idx] = (nv >= thr);
        n.st = 3'd3;
      end
      3'd3: begin
        n.pot[m.idx] = m.spike[m.idx] ? 8'd0 : m.v;
        if (e) begin
          n.st = 3'd1;
          n.idx = m.idx + 2'd1;
        end else begin
          n.st = 3'd0;
        end
      end
      default: n.st = 3'd1;
    endcase
    return n;
  endfunction

  task automatic tick();
    obs_t ea, eb;
    ma = step(ma, rst_n, en, sig_a, 8, 20);
    mb = step(mb, rst_n, en, sig_b, 200, 255);
    qa.push_back({ma.spike, ma.idx, ma.st});
    qb.push_back({mb.spike, mb.idx, mb.st});
    @(posedge clk);
    #1;
    ea = qa.pop_front();
    eb = qb.pop_front();
    checks++;
    if ({if_a.spike_out, if_a.cur_idx, if_a.state_dbg} !== ea) begin
      errors++;
      $display("FAIL cycle_a t=%0t got spike=%b idx=%0d st=%0d want spike=%b idx=%0d st=%0d", $time,
               if_a.spike_out, if_a.cur_idx, if_a.state_dbg, ea.spike, ea.idx, ea.st);
    end
    checks++;
    if ({if_b.spike_out, if_b.cur_idx, if_b.state_dbg} !== eb) begin
      errors++;
      $display("FAIL cycle_b t=%0t got spike=%b idx=%0d st=%0d want spike=%b idx=%0d st=%0d", $time,
               if_b.spike_out, if_b.cur_idx, if_b.state_dbg, eb.spike, eb.idx, eb.st);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b1;
    sig_a = 4'b0;
    sig_b = 4'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_model(input logic [2:0] st, input logic [1:0] idx);
    int n = 0;
    while (!(ma.st == st && ma.idx == idx) && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (!(ma.st == st && ma.idx == idx)) begin
      errors++;
      $display("FAIL wait_timeout got st=%0d idx=%0d want st=%0d idx=%0d", ma.st, ma.idx, st, idx);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (if_a.state_dbg !== 3'd1 || if_a.cur_idx !== 2'd0 || if_a.spike_out !== 4'b0) begin
      errors++;
      $display("FAIL reset_outputs got st=%0d idx=%0d spike=%b want 1 0 0000",
               if_a.state_dbg, if_a.cur_idx, if_a.spike_out);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dut_a.u_rf.mem_q[i] !== 8'd0 || dut_b.u_rf.mem_q[i] !== 8'd0) begin
        errors++;
        $display("FAIL reset_pot[%0d] got %0d/%0d want 0", i, dut_a.u_rf.mem_q[i], dut_b.u_rf.mem_q[i]);
      end
    end
  endtask

  task automatic test_accumulate();
    logic [7:0] exp_pot[3];
    logic [3:0] exp_spk[3];
    exp_pot = '{8'd8, 8'd16, 8'd0};
    exp_spk = '{4'b0000, 4'b0000, 4'b0001};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      wait_model(3'd3, 2'd3);
      sig_a = 4'b0001;
      tick();
      sig_a = 4'b0000;
      tick();
      tick();
      checks++;
      if (if_a.spike_out !== exp_spk[k]) begin
        errors++;
        $display("FAIL accum_spike[%0d] got %b want %b", k, if_a.spike_out, exp_spk[k]);
      end
      tick();
      checks++;
      if (dut_a.u_rf.mem_q[0] !== exp_pot[k]) begin
        errors++;
        $display("FAIL accum_pot[%0d] got %0d want %0d", k, dut_a.u_rf.mem_q[0], exp_pot[k]);
      end
    end
  endtask

  task automatic test_no_input();
    int spikes = 0;
    do_reset();
    repeat (60) begin
      tick();
      if (if_a.spike_out !== 4'b0 || if_b.spike_out !== 4'b0) spikes++;
    end
    checks++;
    if (spikes != 0) begin
      errors++;
      $display("FAIL idle_spikes got %0d want 0", spikes);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dut_a.u_rf.mem_q[i] !== 8'd0 || dut_b.u_rf.mem_q[i] !== 8'd0) begin
        errors++;
        $display("FAIL idle_pot[%0d] got %0d/%0d want 0", i, dut_a.u_rf.mem_q[i], dut_b.u_rf.mem_q[i]);
      end
    end
  endtask

  task automatic test_saturate();
    logic [7:0] exp_pot[2];
    logic [3:0] exp_spk[2];
    exp_pot = '{8'd200, 8'd0};
    exp_spk = '{4'b0000, 4'b0010};
    do_reset();
    for (int k = 0; k < 2; k++) begin
      wait_model(3'd3, 2'd0);
      sig_b = 4'b0010;
      tick();
      sig_b = 4'b0000;
      tick();
      tick();
      checks++;
      if (if_b.spike_out !== exp_spk[k]) begin
        errors++;
        $display("FAIL sat_spike[%0d] got %b want %b", k, if_b.spike_out, exp_spk[k]);
      end
      tick();
      checks++;
      if (dut_b.u_rf.mem_q[1] !== exp_pot[k]) begin
        errors++;
        $display("FAIL sat_pot[%0d] got %0d want %0d", k, dut_b.u_rf.mem_q[1], exp_pot[k]);
      end
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    wait_model(3'd3, 2'd1);
    sig_a = 4'b0100;
    tick();
    tick();
    sig_a = 4'b0000;
    checks++;
    if (dut_a.pend_q[2] !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle_pending got %b want 1", dut_a.pend_q[2]);
    end
    tick();
    tick();
    checks++;
    if (dut_a.u_rf.mem_q[2] !== 8'd8) begin
      errors++;
      $display("FAIL same_cycle_pot1 got %0d want 8", dut_a.u_rf.mem_q[2]);
    end
    wait_model(3'd3, 2'd2);
    tick();
    checks++;
    if (dut_a.u_rf.mem_q[2] !== 8'd16) begin
      errors++;
      $display("FAIL same_cycle_pot2 got %0d want 16", dut_a.u_rf.mem_q[2]);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    do_reset();
    sig_a = 4'b1000;
    while (!(ma.st == 3'd2 && ma.idx == 2'd3 && ma.pot[3] == 8'd16) && n < 200) begin
      tick();
      n++;
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sig_a = 4'b0000;
    checks++;
    if (if_a.state_dbg !== 3'd1 || if_a.cur_idx !== 2'd0 || if_a.spike_out !== 4'b0) begin
      errors++;
      $display("FAIL reset_mid_outputs got st=%0d idx=%0d spike=%b want 1 0 0000",
               if_a.state_dbg, if_a.cur_idx, if_a.spike_out);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dut_a.u_rf.mem_q[i] !== 8'd0) begin
        errors++;
        $display("FAIL reset_mid_pot[%0d] got %0d want 0", i, dut_a.u_rf.mem_q[i]);
      end
    end
    tick();
  endtask

  task automatic test_enable_idle();
    do_reset();
    wait_model(3'd2, 2'd1);
    en = 1'b0;
    tick();
    tick();
    checks++;
    if (if_a.state_dbg !== 3'd0 || if_a.cur_idx !== 2'd1) begin
      errors++;
      $display("FAIL idle_enter got st=%0d idx=%0d want 0 1", if_a.state_dbg, if_a.cur_idx);
    end
    sig_a = 4'b0100;
    tick();
    sig_a = 4'b0000;
    repeat (3) tick();
    checks++;
    if (if_a.state_dbg !== 3'd0) begin
      errors++;
      $display("FAIL idle_hold got st=%0d want 0", if_a.state_dbg);
    end
    en = 1'b1;
    tick();
    checks++;
    if (if_a.state_dbg !== 3'd1 || if_a.cur_idx !== 2'd1) begin
      errors++;
      $display("FAIL idle_resume got st=%0d idx=%0d want 1 1", if_a.state_dbg, if_a.cur_idx);
    end
    wait_model(3'd3, 2'd2);
    tick();
    checks++;
    if (dut_a.u_rf.mem_q[2] !== 8'd8) begin
      errors++;
      $display("FAIL idle_event_pot got %0d want 8", dut_a.u_rf.mem_q[2]);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      sig_a = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      sig_b = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      en = ($urandom_range(0, 9) != 0);
      tick();
    end
    en = 1'b1;
    sig_a = 4'b0;
    sig_b = 4'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dut_a.u_rf.mem_q[i] !== ma.pot[i] || dut_b.u_rf.mem_q[i] !== mb.pot[i]) begin
        errors++;
        $display("FAIL random_pot[%0d] got %0d/%0d want %0d/%0d", i,
                 dut_a.u_rf.mem_q[i], dut_b.u_rf.mem_q[i], ma.pot[i], mb.pot[i]);
      end
    end
  endtask

  initial begin
    ma = '0;
    mb = '0;
    test_reset();
    test_accumulate();
    test_no_input();
    test_saturate();
    test_same_cycle();
    test_reset_mid();
    test_enable_idle();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lif_tdm_scheduler.md
LIF_TDM_SCHEDULER -- requirements
Module: lif_tdm_scheduler

Interface
REQ-001 Parameter N_NEURONS, default 4: number of virtual neurons sharing one accumulator datapath; power of two, 2..16.
REQ-002 Parameter WIDTH, default 8: membrane potential width, unsigned.
REQ-003 Parameters THRESH (8'd20), ADD_W (8'd20), LEAK (8'd1), VRESET (8'd0): fire threshold, input weight, per-service leak and post-spike potential, each WIDTH bits.
REQ-004 Parameter REFRACT, default 2: refractory length in service rounds; used only under LIF_REFRACTORY_EN.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, synchronous and active-low.
REQ-007 enable  input  1  high: scheduler runs; low: parks in IDLE at the next slot boundary.
REQ-008 signal_in  input  N_NEURONS  per-neuron input events, level-sampled every cycle.
REQ-009 spike_out  output  N_NEURONS  one-cycle spike pulse per neuron, registered.
REQ-010 cur_idx  output  log2(N_NEURONS)  index of the neuron currently being serviced.
REQ-011 state_dbg  output  3  FSM state code: IDLE=0, LOAD=1, UPDATE=2, WRITE=3.

Function
REQ-012 pending[i] SHALL be set in any cycle signal_in[i]=1, and cleared only when LOAD of neuron i consumes it; set and consume in the same cycle leaves pending[i]=1.
REQ-013 FSM SHALL sequence LOAD -> UPDATE -> WRITE per neuron, one cycle each; service period is 3*N_NEURONS cycles while enable=1.
REQ-014 LOAD SHALL read v=pot[cur_idx] and latch in_evt=pending[cur_idx].
REQ-015 UPDATE SHALL compute v+ADD_W saturating at 2^WIDTH-1 if in_evt, else v-LEAK floored at 0.
REQ-016 WRITE SHALL store VRESET and assert spike_out[cur_idx] for exactly that cycle if the updated v >= THRESH, else store the updated v; all other spike_out bits SHALL be 0.
REQ-017 After WRITE, cur_idx SHALL increment, wrapping from N_NEURONS-1 to 0.
REQ-018 At a WRITE with enable=0, the FSM SHALL go to IDLE and hold cur_idx; from IDLE, enable=1 SHALL enter LOAD next cycle. enable changes mid-slot SHALL NOT abort the slot.
REQ-019 pending SHALL keep accumulating while in IDLE.

Reset
REQ-020 While rst_n=0 at a clock edge: all pot=0, pending=0, spike_out=0, cur_idx=0, state=LOAD (state_dbg=1); reset overrides every in-progress slot, with no partial write.
REQ-021 Under LIF_REFRACTORY_EN, all refractory counters SHALL reset to 0.

Configuration
REQ-022 Macro LIF_REFRACTORY_EN defined: a spiking neuron loads its counter with REFRACT; while the counter is nonzero, its LOAD discards pending (clears it), UPDATE holds v at VRESET, and WRITE decrements the counter.
REQ-023 LIF_REFRACTORY_EN undefined: no counters are instantiated and behaviour is exactly REQ-012..019.

Structure
REQ-024 Shared package lif_pkg SHALL hold the FSM state encoding (IDLE/LOAD/UPDATE/WRITE) and default WIDTH/THRESH/ADD_W/LEAK/VRESET constants.
REQ-025 Potentials SHALL live in sub-module lif_potential_rf: N_NEURONS x WIDTH, 1 read and 1 synchronous write port, with synchronous clear on rst_n.

Verification
REQ-026 Defaults, ADD_W=8: pulse signal_in[0] for 1 cycle before each of 3 consecutive services of neuron 0 -> pot 8, 16, 24; spike_out[0] pulses on the 3rd WRITE; pot[0]=0 afterward.
REQ-027 No input for 5 rounds from reset -> every pot stays 0 (no wrap to 255) and spike_out stays 0.
REQ-028 ADD_W=200, THRESH=255: two events on neuron 1 -> pot 200, then 255 (not 144); spike_out[1] pulses on the second WRITE.
REQ-029 signal_in[2]=1 exactly in neuron 2's LOAD cycle -> consumed and pending[2] still 1; neuron 2 receives an event again on its next service.
REQ-030 rst_n=0 for 1 cycle during UPDATE of neuron 3 with a pending fire -> no spike_out; next cycle state_dbg=1, cur_idx=0, all pots 0.
REQ-031 enable=0 mid-UPDATE -> WRITE completes, then state_dbg=0 with cur_idx held; events arriving in IDLE are applied after enable returns to 1. With LIF_REFRACTORY_EN and REFRACT=2: events in the 2 rounds after a spike are ignored.
